// File: rtl/hello.sv
// Single-bit level conditioner: 2-flop synchronizer + stability filter driving B,
// with one-cycle rise/fall pulses. Define HELLO_EDGE_COUNT_EN to add a saturating transition counter.
module hello #(
    parameter int FILTER_CYCLES = 4,
    parameter int EDGE_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  A,
    output logic                  B,
    output logic                  rise,
    output logic                  fall
`ifdef HELLO_EDGE_COUNT_EN
    ,
    output logic [EDGE_CNT_W-1:0] edge_cnt,
    input  logic                  cnt_clr
`endif
);

    localparam int FC_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);

    logic            s1_reg, s2_reg;
    logic [FC_W-1:0] fc_reg, fc_next;
    logic            b_reg, b_next;
    logic            rise_reg, rise_next;
    logic            fall_reg, fall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            fc_reg   <= '0;
            b_reg    <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s1_reg   <= A;
            s2_reg   <= s1_reg;
            fc_reg   <= fc_next;
            b_reg    <= b_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    // Any cycle where the synced input agrees with B restarts the stability count.
    always_comb begin
        fc_next   = '0;
        b_next    = b_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (s2_reg != b_reg) begin
            if (fc_reg == FC_LAST) begin
                b_next    = s2_reg;
                rise_next = s2_reg;
                fall_next = ~s2_reg;
            end else begin
                fc_next = fc_reg + 1'b1;
            end
        end
    end

    always_comb begin
        B    = b_reg;
        rise = rise_reg;
        fall = fall_reg;
    end

`ifdef HELLO_EDGE_COUNT_EN
    logic [EDGE_CNT_W-1:0] edge_cnt_reg, edge_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt_reg <= '0;
        else        edge_cnt_reg <= edge_cnt_next;
    end

    // Clear has priority over a same-cycle increment; count saturates at all-ones.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        if (cnt_clr)
            edge_cnt_next = '0;
        else if ((rise_reg | fall_reg) && (edge_cnt_reg != '1))
            edge_cnt_next = edge_cnt_reg + 1'b1;
    end

    assign edge_cnt = edge_cnt_reg;
`endif

endmodule

// File: tb/tb_hello.sv
// Directed bench for hello: reset, follow latency, glitch rejection, FILTER_CYCLES=1,
// reset mid-filter, and (with HELLO_EDGE_COUNT_EN) the saturating edge counter.
module tb_hello;

    logic clk = 1'b0;
    logic rst_n;
    logic a, a1;
    logic b, rise, fall;
    logic b1, rise1, fall1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hello #(.FILTER_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .rise(rise), .fall(fall)
`ifdef HELLO_EDGE_COUNT_EN
        , .edge_cnt(), .cnt_clr(1'b0)
`endif
    );

    hello #(.FILTER_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .rise(rise1), .fall(fall1)
`ifdef HELLO_EDGE_COUNT_EN
        , .edge_cnt(), .cnt_clr(1'b0)
`endif
    );

`ifdef HELLO_EDGE_COUNT_EN
    logic       a2, b2, rise2, fall2, cnt_clr;
    logic [1:0] edge_cnt2;
    hello #(.FILTER_CYCLES(4), .EDGE_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .rise(rise2), .fall(fall2),
        .edge_cnt(edge_cnt2), .cnt_clr(cnt_clr)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seg_vals [5];
        logic prev;
        int   n_rise, n_fall;

        rst_n = 1'b0;
        a     = 1'b1;
        a1    = 1'b0;
`ifdef HELLO_EDGE_COUNT_EN
        a2      = 1'b0;
        cnt_clr = 1'b0;
`endif

        // 1: everything stays 0 while reset is held, even with A toggling
        for (int i = 0; i < 8; i++) begin
            tick();
            a = ~a;
            chk("rst_B", {31'd0, b}, 32'd0);
            chk("rst_rise", {31'd0, rise}, 32'd0);
            chk("rst_fall", {31'd0, fall}, 32'd0);
`ifdef HELLO_EDGE_COUNT_EN
            chk("rst_cnt", {30'd0, edge_cnt2}, 32'd0);
`endif
        end
        a = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rel_pulse", {30'd0, rise, fall}, 32'd0);
            chk("rel_B", {31'd0, b}, 32'd0);
        end

        // 2: follow sequence 0,1,1,0,1 with 6-edge latency
        seg_vals = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        prev   = 1'b0;
        n_rise = 0;
        n_fall = 0;
        for (int s = 0; s < 5; s++) begin
            a = seg_vals[s];
            for (int j = 1; j <= 20; j++) begin
                tick();
                n_rise += int'(rise);
                n_fall += int'(fall);
                chk($sformatf("seq%0d_B_t%0d", s, j), {31'd0, b},
                    {31'd0, (j >= 6) ? seg_vals[s] : prev});
                chk($sformatf("seq%0d_rise_t%0d", s, j), {31'd0, rise},
                    {31'd0, (j == 6) && seg_vals[s] && !prev});
                chk($sformatf("seq%0d_fall_t%0d", s, j), {31'd0, fall},
                    {31'd0, (j == 6) && !seg_vals[s] && prev});
            end
            prev = seg_vals[s];
        end
        chk("seq_rise_total", n_rise, 32'd2);
        chk("seq_fall_total", n_fall, 32'd1);

        // 3: 3-clock glitch must be rejected
        a = 1'b0;
        repeat (10) tick();
        chk("glitch_pre_B", {31'd0, b}, 32'd0);
        a = 1'b1;
        repeat (3) tick();
        a = 1'b0;
        for (int j = 0; j < 15; j++) begin
            tick();
            chk("glitch_B", {31'd0, b}, 32'd0);
            chk("glitch_pulse", {30'd0, rise, fall}, 32'd0);
        end

        // 4: FILTER_CYCLES=1 gives 3-edge latency
        a1 = 1'b1;
        tick();
        tick();
        chk("f1_B_t2", {31'd0, b1}, 32'd0);
        chk("f1_rise_t2", {31'd0, rise1}, 32'd0);
        tick();
        chk("f1_B_t3", {31'd0, b1}, 32'd1);
        chk("f1_rise_t3", {31'd0, rise1}, 32'd1);
        chk("f1_fall_t3", {31'd0, fall1}, 32'd0);
        tick();
        chk("f1_rise_t4", {31'd0, rise1}, 32'd0);
        chk("f1_B_t4", {31'd0, b1}, 32'd1);

        // 5: reset mid-filter discards progress
        a = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_B", {31'd0, b}, 32'd0);
        chk("midrst_b1", {31'd0, b1}, 32'd0);
        tick();
        tick();
        chk("midrst_hold_B", {31'd0, b}, 32'd0);
        rst_n = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("midrst_B_t%0d", j), {31'd0, b}, 32'd0);
        end
        tick();
        chk("midrst_B_t6", {31'd0, b}, 32'd1);
        chk("midrst_rise_t6", {31'd0, rise}, 32'd1);
        tick();
        chk("midrst_rise_t7", {31'd0, rise}, 32'd0);

`ifdef HELLO_EDGE_COUNT_EN
        // 6: 2-bit counter saturates at 3; clear beats a same-cycle increment
        for (int t = 1; t <= 5; t++) begin
            a2 = ~a2;
            repeat (10) tick();
            chk($sformatf("cnt_after_%0d", t), {30'd0, edge_cnt2}, (t > 3) ? 32'd3 : t);
        end
        a2 = 1'b0;
        repeat (10) tick();
        chk("cnt_sat_hold", {30'd0, edge_cnt2}, 32'd3);
        a2 = 1'b1;
        repeat (6) tick();
        chk("cnt_rise_seen", {31'd0, rise2}, 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", {30'd0, edge_cnt2}, 32'd0);
        repeat (3) tick();
        chk("cnt_clr_stays", {30'd0, edge_cnt2}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
